// File: rtl/tcp_tx_sched.sv
// ---------------------------------------------------------------------------
// tcp_tx_sched
//
// Round-robin scheduler that multiplexes NCH per-channel byte sources onto
// the single SiTCP TCP transmit byte stream. When enabled (run) and the TCP
// connection is open (open_ack), one eligible channel is granted at a time.
// The granted channel gets a 4-byte header (SYNC, channel, len[15:8],
// len[7:0]) followed by exactly the latched frame_len payload bytes. Back-
// pressure from SiTCP (tx_full) stalls both header and payload issue.
//
// Ports
//   clk        system clock
//   sys_rst    asynchronous active-low reset
//   open_ack   TCP connection established; low aborts and clears frame_cnt
//   run        level enable; a running frame always completes
//   ch_mask    per-channel eligibility (1 = may be granted)
//   frame_len  payload bytes per frame, latched at grant
//   src_valid  per-channel byte valid
//   src_data   per-channel byte, channel i at [8i+7:8i]
//   src_ready  per-channel byte accept (one-hot or zero), combinational
//   tx_full    SiTCP TX almost-full
//   tx_wr      registered TX write strobe
//   tx_data    registered TX byte
//   busy       registered, high in any state except IDLE
//   cur_ch     currently or last granted channel
//   frame_cnt  frames completed since the connection opened
// ---------------------------------------------------------------------------
module tcp_tx_sched #(
  parameter int         NCH  = 8,
  parameter logic [7:0] SYNC = 8'hA5,
  parameter int         CHW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             open_ack,
  input  logic             run,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [15:0]      frame_len,
  input  logic [NCH-1:0]   src_valid,
  input  logic [NCH*8-1:0] src_data,
  output logic [NCH-1:0]   src_ready,
  input  logic             tx_full,
  output logic             tx_wr,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic [CHW-1:0]   cur_ch,
  output logic [31:0]      frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_HDR  = 2'd2;
  localparam logic [1:0] S_PAY  = 2'd3;

  logic [1:0]     state_q,     state_d;
  logic [CHW-1:0] cur_ch_q,    cur_ch_d;
  logic [15:0]    rem_q,       rem_d;
  logic [1:0]     hdr_idx_q,   hdr_idx_d;
  logic           tx_wr_q,     tx_wr_d;
  logic [7:0]     tx_data_q,   tx_data_d;
  logic           busy_q,      busy_d;
  logic [31:0]    frame_cnt_q, frame_cnt_d;

  logic [NCH-1:0] elig;
  logic           grant_vld;
  logic [CHW-1:0] grant_ch;
  logic [CHW:0]   rr_sum;
  logic [CHW-1:0] rr_idx;
  logic [7:0]     hdr_byte;
  logic [7:0]     cur_byte;
  logic           cur_valid;
  logic           pay_xfer;

  // Round-robin search: first eligible channel starting at cur_ch+1, with
  // wrap-around. The extra bit on rr_sum lets NCH be a non-power of two.
  always_comb begin
    elig      = ch_mask & src_valid;
    grant_vld = 1'b0;
    grant_ch  = cur_ch_q;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NCH; k++) begin
      rr_sum = {1'b0, cur_ch_q} + (CHW+1)'(k);
      if (rr_sum >= (CHW+1)'(NCH)) rr_sum = rr_sum - (CHW+1)'(NCH);
      rr_idx = rr_sum[CHW-1:0];
      if (!grant_vld && elig[rr_idx]) begin
        grant_vld = 1'b1;
        grant_ch  = rr_idx;
      end
    end
  end

  // Header bytes come from the latched length held in rem_q, which is not
  // decremented until payload starts, so frame_len edits cannot leak in.
  always_comb begin
    case (hdr_idx_q)
      2'd0:    hdr_byte = SYNC;
      2'd1:    hdr_byte = 8'(cur_ch_q);
      2'd2:    hdr_byte = rem_q[15:8];
      default: hdr_byte = rem_q[7:0];
    endcase
  end

  assign cur_byte  = src_data[{cur_ch_q, 3'b000} +: 8];
  assign cur_valid = src_valid[cur_ch_q];

  // src_ready is also gated by open_ack so a source never hands over a byte
  // in the cycle the connection drops; that byte would otherwise be lost.
  always_comb begin
    src_ready = '0;
    if (state_q == S_PAY && !tx_full && open_ack) src_ready[cur_ch_q] = 1'b1;
  end

  assign pay_xfer = cur_valid & src_ready[cur_ch_q];

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    rem_d       = rem_q;
    hdr_idx_d   = hdr_idx_q;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (run && open_ack) state_d = S_ARB;
      end

      S_ARB: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (grant_vld) begin
          cur_ch_d  = grant_ch;
          rem_d     = frame_len;
          hdr_idx_d = 2'd0;
          state_d   = S_HDR;
        end
      end

      S_HDR: begin
        if (!tx_full) begin
          tx_wr_d   = 1'b1;
          tx_data_d = hdr_byte;
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            // A zero-length frame is header only but still counts.
            if (rem_q == 16'd0) begin
              frame_cnt_d = frame_cnt_q + 32'd1;
              state_d     = S_ARB;
            end else begin
              state_d = S_PAY;
            end
          end
        end
      end

      S_PAY: begin
        if (pay_xfer) begin
          tx_wr_d   = 1'b1;
          tx_data_d = cur_byte;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            state_d     = S_ARB;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Connection loss overrides everything: abandon the frame, no write.
    if (!open_ack) begin
      state_d     = S_IDLE;
      tx_wr_d     = 1'b0;
      frame_cnt_d = 32'd0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= S_IDLE;
      cur_ch_q    <= CHW'(NCH - 1);
      rem_q       <= '0;
      hdr_idx_q   <= '0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      rem_q       <= rem_d;
      hdr_idx_q   <= hdr_idx_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_wr     = tx_wr_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign cur_ch    = cur_ch_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tcp_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_tcp_tx_sched
//
// Directed bench for tcp_tx_sched. Per-channel byte sources are modelled as
// queues; expected TX bytes are pushed to a scoreboard queue when a frame is
// set up and popped as tx_wr strobes appear.
// ---------------------------------------------------------------------------
module tb_tcp_tx_sched;

  localparam int NCH = 8;
  localparam int CHW = 3;

  logic             clk = 1'b0;
  logic             sys_rst;
  logic             open_ack;
  logic             run;
  logic [NCH-1:0]   ch_mask;
  logic [15:0]      frame_len;
  logic [NCH-1:0]   src_valid;
  logic [NCH*8-1:0] src_data;
  logic [NCH-1:0]   src_ready;
  logic             tx_full;
  logic             tx_wr;
  logic [7:0]       tx_data;
  logic             busy;
  logic [CHW-1:0]   cur_ch;
  logic [31:0]      frame_cnt;

  tcp_tx_sched #(.NCH(NCH), .SYNC(8'hA5)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .open_ack  (open_ack),
    .run       (run),
    .ch_mask   (ch_mask),
    .frame_len (frame_len),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .tx_full   (tx_full),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .busy      (busy),
    .cur_ch    (cur_ch),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  logic [NCH-1:0] hs = '0;
  logic [NCH-1:0] ready_seen = '0;
  logic [7:0] srcq [NCH][$];
  logic [7:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Source model and TX monitor. Handshakes sampled just after the falling
  // edge are the ones taken at the following rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    for (int i = 0; i < NCH; i++)
      if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    for (int i = 0; i < NCH; i++) begin
      src_valid[i]      = (srcq[i].size() > 0);
      src_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
    end
    #1;
    hs = src_ready & src_valid;
    ready_seen = ready_seen | src_ready;
    chk("ready_onehot", 32'($onehot0(src_ready)), 32'd1);
    if (tx_wr) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e));
      end else begin
        chk("unexpected_wr", 32'(tx_wr), 32'd0);
      end
    end
  end

  task automatic push_frame(input logic [7:0] ch, input logic [15:0] len,
                            input logic [7:0] d0, input int n);
    expq.push_back(8'hA5);
    expq.push_back(ch);
    expq.push_back(len[15:8]);
    expq.push_back(len[7:0]);
    for (int j = 0; j < n; j++) expq.push_back(d0 + 8'(j));
  endtask

  task automatic wait_wr(input int n);
    int k;
    k = 0;
    while (wr_count < n && k < 300) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("wait_wr_count", wr_count, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst  = 1'b0;
    run      = 1'b0;
    open_ack = 1'b0;
    tx_full  = 1'b0;
    for (int i = 0; i < NCH; i++) srcq[i].delete();
    repeat (2) @(negedge clk);
    sys_rst    = 1'b1;
    ready_seen = '0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int arb_cyc;
    int k;

    sys_rst   = 1'b0;
    open_ack  = 1'b0;
    run       = 1'b0;
    ch_mask   = '0;
    frame_len = '0;
    tx_full   = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tx_wr",     32'(tx_wr),     32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cur_ch",    32'(cur_ch),    32'd7);
    chk("rst_frame_cnt", frame_cnt,      32'd0);

    // Single frame on ch0, latency from ARB entry to last write.
    do_reset();
    base = wr_count;
    open_ack  = 1'b1;
    ch_mask   = 8'h01;
    frame_len = 16'd3;
    srcq[0].push_back(8'h11);
    srcq[0].push_back(8'h22);
    srcq[0].push_back(8'h33);
    expq.push_back(8'hA5); expq.push_back(8'h00); expq.push_back(8'h00);
    expq.push_back(8'h03); expq.push_back(8'h11); expq.push_back(8'h22);
    expq.push_back(8'h33);
    @(negedge clk);
    run = 1'b1;
    k = 0;
    arb_cyc = 0;
    while (busy !== 1'b1 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    arb_cyc = cyc;
    wait_wr(base + 7);
    chk("t1_latency",   last_wr_cyc - arb_cyc, 32'd8);
    chk("t1_frame_cnt", frame_cnt, 32'd1);
    chk("t1_cur_ch",    32'(cur_ch), 32'd0);
    chk("t1_sb_empty",  expq.size(), 32'd0);

    // All channels eligible, one payload byte each: 0..7 then wrap to 0.
    do_reset();
    base = wr_count;
    open_ack  = 1'b1;
    ch_mask   = 8'hFF;
    frame_len = 16'd1;
    for (int i = 0; i < NCH; i++) srcq[i].push_back(8'h40 + 8'(i));
    srcq[0].push_back(8'h50);
    for (int f = 0; f < 8; f++) push_frame(8'(f), 16'd1, 8'h40 + 8'(f), 1);
    push_frame(8'h00, 16'd1, 8'h50, 1);
    @(negedge clk);
    run = 1'b1;
    wait_wr(base + 45);
    chk("t2_frame_cnt", frame_cnt, 32'd9);
    chk("t2_cur_ch",    32'(cur_ch), 32'd0);
    chk("t2_sb_empty",  expq.size(), 32'd0);

    // Mask 0x24 with masked channels 0 and 7 also holding data.
    do_reset();
    base = wr_count;
    open_ack  = 1'b1;
    ch_mask   = 8'h24;
    frame_len = 16'd2;
    for (int j = 0; j < 4; j++) begin
      srcq[2].push_back(8'h21 + 8'(j));
      srcq[5].push_back(8'h51 + 8'(j));
    end
    srcq[0].push_back(8'h01);
    srcq[7].push_back(8'h07);
    push_frame(8'h02, 16'd2, 8'h21, 2);
    push_frame(8'h05, 16'd2, 8'h51, 2);
    push_frame(8'h02, 16'd2, 8'h23, 2);
    push_frame(8'h05, 16'd2, 8'h53, 2);
    @(negedge clk);
    run = 1'b1;
    wait_wr(base + 24);
    chk("t3_masked_ready", 32'(ready_seen & 8'hDB), 32'd0);
    chk("t3_ready_seen",   32'(ready_seen), 32'h24);
    chk("t3_frame_cnt",    frame_cnt, 32'd4);
    chk("t3_ch0_untouched", srcq[0].size(), 32'd1);
    chk("t3_sb_empty",     expq.size(), 32'd0);

    // tx_full held for 5 cycles from the first payload cycle.
    do_reset();
    base = wr_count;
    open_ack  = 1'b1;
    ch_mask   = 8'h01;
    frame_len = 16'd4;
    for (int j = 0; j < 4; j++) srcq[0].push_back(8'h61 + 8'(j));
    push_frame(8'h00, 16'd4, 8'h61, 4);
    @(negedge clk);
    run = 1'b1;
    wait_wr(base + 3);
    @(negedge clk);
    tx_full = 1'b1;
    for (int h = 0; h < 5; h++) begin
      #2;
      chk("t4_hold_ready", 32'(src_ready), 32'd0);
      if (h > 0) chk("t4_hold_wr", 32'(tx_wr), 32'd0);
      @(negedge clk);
    end
    tx_full = 1'b0;
    wait_wr(base + 8);
    chk("t4_frame_cnt", frame_cnt, 32'd1);
    chk("t4_sb_empty",  expq.size(), 32'd0);

    // open_ack dropped after 2 of 6 payload bytes, then reopen.
    do_reset();
    base = wr_count;
    open_ack  = 1'b1;
    ch_mask   = 8'h01;
    frame_len = 16'd1;
    srcq[0].push_back(8'h70);
    push_frame(8'h00, 16'd1, 8'h70, 1);
    @(negedge clk);
    run = 1'b1;
    wait_wr(base + 5);
    chk("t5_frame_cnt_pre", frame_cnt, 32'd1);
    @(negedge clk);
    frame_len = 16'd6;
    srcq[0].push_back(8'h71);
    srcq[0].push_back(8'h72);
    push_frame(8'h00, 16'd6, 8'h71, 2);
    wait_wr(base + 11);
    repeat (3) @(negedge clk);
    chk("t5_stall_busy", 32'(busy), 32'd1);
    open_ack = 1'b0;
    @(negedge clk);
    #2;
    chk("t5_drop_busy",      32'(busy),      32'd0);
    chk("t5_drop_tx_wr",     32'(tx_wr),     32'd0);
    chk("t5_drop_frame_cnt", frame_cnt,      32'd0);
    chk("t5_drop_ready",     32'(src_ready), 32'd0);
    @(negedge clk);
    open_ack  = 1'b1;
    frame_len = 16'd1;
    srcq[0].push_back(8'h7F);
    push_frame(8'h00, 16'd1, 8'h7F, 1);
    wait_wr(base + 16);
    chk("t5_reopen_frame_cnt", frame_cnt, 32'd1);
    chk("t5_sb_empty", expq.size(), 32'd0);

    // Header-only frame on ch3; run drops mid-header so exactly one frame.
    do_reset();
    base = wr_count;
    open_ack  = 1'b1;
    ch_mask   = 8'h08;
    frame_len = 16'd0;
    srcq[3].push_back(8'h33);
    push_frame(8'h03, 16'd0, 8'h00, 0);
    @(negedge clk);
    run = 1'b1;
    wait_wr(base + 2);
    @(negedge clk);
    run = 1'b0;
    wait_wr(base + 4);
    repeat (4) @(negedge clk);
    #2;
    chk("t6_busy",        32'(busy),       32'd0);
    chk("t6_frame_cnt",   frame_cnt,       32'd1);
    chk("t6_ready_never", 32'(ready_seen), 32'd0);
    chk("t6_src_kept",    srcq[3].size(),  32'd1);
    chk("t6_wr_total",    wr_count,        base + 4);
    chk("t6_sb_empty",    expq.size(),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tcp_tx_sched.md
# tcp_tx_sched

Round-robin scheduler that shares the SiTCP TCP transmit byte stream between `NCH` channel sources in the DAQ path. When enabled and the TCP connection is open, it grants one eligible channel at a time. For that channel it emits a 4-byte frame header and then exactly `frame_len` payload bytes into the SiTCP TX write port, honouring `tx_full` back-pressure. It sits between the per-channel packet builders and the SiTCP `TCP_TX_WR`/`TCP_TX_DATA` inputs. It is configured from the RBCP register block (`channel_ctrl`, `data_number`, `trigger_cmd`).

## Interface
Parameters:
- `NCH`, 8: number of channel sources, 2..16
- `SYNC`, 8'hA5: first header byte
- `CHW`, $clog2(NCH): width of the channel index

Ports:
- `clk`  in  1  system clock (200 MHz domain)
- `sys_rst`  in  1  asynchronous, active-low reset
- `open_ack`  in  1  TCP connection established (SiTCP `TCP_OPEN_ACK`)
- `run`  in  1  level enable (from `trigger_cmd`)
- `ch_mask`  in  NCH  per-channel enable (from `channel_ctrl`); 1 = eligible
- `frame_len`  in  16  payload bytes per frame (from `data_number[15:0]`)
- `src_valid`  in  NCH  per-channel byte valid
- `src_data`  in  NCH*8  per-channel byte; channel i occupies bits [8i+7:8i]
- `src_ready`  out  NCH  per-channel byte accept (one-hot or zero)
- `tx_full`  in  1  SiTCP TX almost-full
- `tx_wr`  out  1  TX byte write strobe
- `tx_data`  out  8  TX byte
- `busy`  out  1  high in any state except IDLE
- `cur_ch`  out  CHW  currently or last granted channel
- `frame_cnt`  out  32  frames completed since connection open

## Operation
- States: IDLE, ARB, HDR, PAY.
- **IDLE**
  - Go to ARB when `run & open_ack`.
- **ARB** (one cycle per evaluation)
  - Eligible = `ch_mask & src_valid`.
  - If none are eligible, stay in ARB. If `run` is low, go to IDLE.
  - Otherwise, grant the first eligible channel searching from `cur_ch+1` upward with wrap-around (round-robin).
  - On a grant: load `cur_ch`, latch `frame_len` into a 16-bit remaining counter, go to HDR.
- **HDR**
  - Emits 4 bytes in order: `SYNC`, `{(8-CHW)'b0, cur_ch}`, `len[15:8]`, `len[7:0]`. `len` is the latched value.
  - Advances one byte per cycle in which `tx_full`=0.
  - After byte 4: go to PAY, or to ARB if the latched length is 0 (header-only frame, still counted).
- **PAY**
  - `src_ready[cur_ch] = ~tx_full`; all other `src_ready` bits are 0.
  - A byte transfers when `src_valid[cur_ch] & src_ready[cur_ch]`. Each transfer decrements the remaining counter.
  - When the counter reaches 0: `frame_cnt` += 1 (wraps at 2^32), go to ARB.
  - A gap in `src_valid` stalls the frame indefinitely. Nothing is written during the gap.
- `run` deasserted mid-frame: the current frame completes, then ARB sees `run`=0 and goes to IDLE.
- `open_ack` low in any state: next cycle go to IDLE, clear `tx_wr`, clear `frame_cnt`, drop `src_ready`. A partial frame is abandoned; SiTCP discards its buffer on close.
- `ch_mask` changes take effect at the next ARB evaluation only; a granted frame is never cut short.
- `frame_len` changes mid-frame are ignored.

## Timing
- Reset values: state IDLE, `tx_wr`=0, `tx_data`=0, `src_ready`=0, `busy`=0, `cur_ch`=NCH-1 (so the first grant searches from channel 0), `frame_cnt`=0, remaining counter 0.
- `tx_wr`/`tx_data` are registered. A header byte issued, or a payload byte accepted, in cycle N appears on `tx_wr`=1 in cycle N+1.
- `src_ready` is combinational from state and `tx_full`.
- `tx_full` sampled high in cycle N means no byte is issued or accepted in N. This relies on SiTCP almost-full margin; one extra in-flight byte is permitted.
- Minimum frame time is 1 (ARB) + 4 (HDR) + `frame_len` cycles with no stalls.
- Back-to-back frames have exactly one idle ARB cycle between them.
- `busy` and `cur_ch` are registered with the state.

## Test plan
- Reset, `open_ack`=1, `run`=1, `ch_mask`=8'h01, `frame_len`=3, ch0 streams 11,22,33 -> `tx_data` sequence A5,00,00,03,11,22,33; `frame_cnt`=1; 8 cycles from ARB entry to the last `tx_wr`.
- All channels valid, `ch_mask`=8'hFF, `frame_len`=1 -> header channel bytes 00,01,…,07,00 (round-robin with wrap).
- `ch_mask`=8'h24, ch2 and ch5 valid, `frame_len`=2 -> grants alternate 2,5,2,5; channels 0,1,3,4,6,7 never see `src_ready`.
- `tx_full` held high for 5 cycles during PAY with `frame_len`=4 -> no `tx_wr` and no `src_ready` during the hold; all 4 bytes delivered in order afterwards.
- `open_ack` dropped after 2 of 6 payload bytes -> next cycle IDLE, `tx_wr`=0, `frame_cnt`=0; after reopen, the next frame starts with A5.
- `frame_len`=0 with ch3 eligible -> only A5,03,00,00 emitted; `frame_cnt` increments; `src_ready` never asserted.
